// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver state encoding, the frame data width and the default
// bit period used by uart_rx_core and uart_rx_fifo.
package uart_rx_core_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int DEFAULT_BAUD_DIV = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead receive FIFO.
// Ports:
//   clk, reset (sync, active-low)
//   push, push_data : write strobe and byte
//   pop             : read strobe, ignored while empty
//   head            : oldest entry, 0 when empty
//   count           : occupancy 0..FIFO_DEPTH
//   full, empty     : occupancy status
module uart_rx_fifo
    import uart_rx_core_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic [ADDR_WIDTH:0]       count,
    output logic                      full,
    output logic                      empty
);

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic                      do_push;
    logic                      do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_WIDTH+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (do_push && !do_pop) begin
                count <= count + (ADDR_WIDTH+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receive engine.
// Synchronises rxd, times each bit from the start-bit falling edge, samples
// mid-bit, and pushes completed bytes into a show-ahead FIFO.
// Ports:
//   clk, reset (sync, active-low)
//   rxd       : asynchronous serial input, idles high
//   rd_en     : pop strobe from an SBUF read
//   int_clr   : clears rx_int
//   err_clr   : clears frame_err and overrun
//   rd_data   : FIFO head, 0 when empty
//   rx_int    : sticky byte-received flag
//   frame_err : sticky stop-bit-low flag
//   overrun   : sticky byte-dropped flag
//   count     : FIFO occupancy
//   busy      : receiver not idle
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    input  logic                      rd_en,
    input  logic                      int_clr,
    input  logic                      err_clr,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      rx_int,
    output logic                      frame_err,
    output logic                      overrun,
    output logic [ADDR_WIDTH:0]       count,
    output logic                      busy
);

    localparam logic [CNT_WIDTH-1:0] BIT_LOAD  = CNT_WIDTH'(BAUD_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_LOAD = CNT_WIDTH'(BAUD_DIV / 2 - 1);
    localparam logic [2:0]           LAST_BIT  = 3'(UART_DATA_BITS - 1);

    state_t                    state;
    logic                      rxd_meta;
    logic                      rxd_s;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;

    logic stop_tick;
    logic stop_ok;
    logic fifo_take;
    logic fifo_full;
    logic fifo_empty;

    // Two-flop synchroniser; reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    assign stop_tick = (state == STOP) && (cnt == '0);
    assign stop_ok   = stop_tick && rxd_s;
    // Mirrors the FIFO's accept rule so overrun and rx_int agree with it.
    assign fifo_take = !fifo_full || (rd_en && !fifo_empty);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            rx_int    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end else if (rxd_s) begin
                        state <= IDLE;
                    end else begin
                        cnt     <= BIT_LOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end else begin
                        cnt <= BIT_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end else if (rxd_s) begin
                        state <= IDLE;
                    end else begin
                        state <= BREAK;
                    end
                end
                BREAK: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Sticky flags: a set in the same cycle as a clear wins.
            if (stop_ok && fifo_take) rx_int <= 1'b1;
            else if (int_clr)         rx_int <= 1'b0;

            if (stop_tick && !rxd_s) frame_err <= 1'b1;
            else if (err_clr)        frame_err <= 1'b0;

            if (stop_ok && !fifo_take) overrun <= 1'b1;
            else if (err_clr)          overrun <= 1'b0;
        end
    end

    // Shift register holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (state == DATA && cnt == '0) begin
            shift[bit_idx] <= rxd_s;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (stop_ok),
        .push_data (shift),
        .pop       (rd_en),
        .head      (rd_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
